// File: rtl/gamma_iter.sv
// gamma_iter: iterative Anubis gamma layer, SBOXES S-box lookups per cycle over a BYTES-wide state.
// Defining GAMMA_ITER_BLKCNT_EN adds the blk_count output-handshake counter.

module sbox (
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    localparam logic [7:0] TABLE [256] = '{
        8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79, 8'h3a, 8'hc9, 8'h91, 8'hfc, 8'h1e, 8'h47, 8'h54, 8'hbd,
        8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4, 8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2,
        8'h39, 8'hdf, 8'h29, 8'hda, 8'h2b, 8'ha8, 8'hcb, 8'h4c, 8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
        8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff, 8'h60, 8'h20, 8'h08, 8'h8b, 8'h5e, 8'hab, 8'h7f, 8'h78,
        8'h7c, 8'h2c, 8'h57, 8'hd2, 8'hdc, 8'h6d, 8'h7e, 8'h0d, 8'h53, 8'h94, 8'hc3, 8'h28, 8'h27, 8'h06, 8'h5f, 8'had,
        8'h67, 8'h5c, 8'h55, 8'h48, 8'h0e, 8'h52, 8'hea, 8'h42, 8'h5b, 8'h5d, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3c, 8'h4e,
        8'h38, 8'h8a, 8'h72, 8'h14, 8'he7, 8'hc6, 8'hde, 8'h50, 8'h8e, 8'h92, 8'hd1, 8'h77, 8'h93, 8'h45, 8'h9a, 8'hce,
        8'h2d, 8'h03, 8'h62, 8'hb6, 8'hb9, 8'hbf, 8'h96, 8'h6b, 8'h3f, 8'h07, 8'h12, 8'hae, 8'h40, 8'h34, 8'h46, 8'h3e,
        8'hdb, 8'hcf, 8'hec, 8'hcc, 8'hc1, 8'ha1, 8'hc0, 8'hd6, 8'h1d, 8'hf4, 8'h61, 8'h3b, 8'h10, 8'hd8, 8'h68, 8'ha0,
        8'hb1, 8'h0a, 8'h69, 8'h6c, 8'h49, 8'hfa, 8'h76, 8'hc4, 8'h9e, 8'h9b, 8'h6e, 8'h99, 8'hc2, 8'hb7, 8'h98, 8'hbc,
        8'h8f, 8'h85, 8'h1f, 8'hb4, 8'hf8, 8'h11, 8'h2e, 8'h00, 8'h25, 8'h1c, 8'h2a, 8'h3d, 8'h05, 8'h4f, 8'h7b, 8'hb2,
        8'h32, 8'h90, 8'haf, 8'h19, 8'ha3, 8'hf7, 8'h73, 8'h9d, 8'h15, 8'h74, 8'hee, 8'hca, 8'h9f, 8'h0f, 8'h1b, 8'h75,
        8'h86, 8'h84, 8'h9c, 8'h4a, 8'h97, 8'h1a, 8'h65, 8'hf6, 8'hed, 8'h09, 8'hbb, 8'h26, 8'h83, 8'heb, 8'h6f, 8'h81,
        8'h04, 8'h6a, 8'h43, 8'h01, 8'h17, 8'he1, 8'h87, 8'hf5, 8'h8d, 8'he3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
        8'hfe, 8'hd5, 8'h31, 8'hd9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hf2, 8'hf1, 8'h56, 8'hcd, 8'h82, 8'hc8, 8'hba, 8'hf0,
        8'hef, 8'he9, 8'he8, 8'hfd, 8'h89, 8'hd7, 8'hc7, 8'hb5, 8'ha4, 8'h2f, 8'h95, 8'h13, 8'h0b, 8'hf3, 8'he0, 8'h37
    };

    assign o_y = TABLE[i_x];
endmodule

module gamma_iter #(
    parameter int BYTES  = 16,
    parameter int SBOXES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*BYTES-1:0]   data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*BYTES-1:0]   data_out
`ifdef GAMMA_ITER_BLKCNT_EN
    ,
    output logic [31:0]          blk_count
`endif
);
    localparam int ROUNDS = BYTES / SBOXES;
    localparam int CW     = $clog2(ROUNDS + 1);
    localparam int W      = 8 * BYTES;
    localparam int SW     = 8 * SBOXES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_work, w_work_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [SW-1:0] w_sub;
    logic [W-1:0]  w_rot;

    if (BYTES % SBOXES != 0) begin : g_bad_cfg
        $error("gamma_iter: SBOXES must divide BYTES");
    end

    // The top SBOXES bytes are substituted each cycle, then rotated to the bottom.
    for (genvar g = 0; g < SBOXES; g++) begin : g_sbox
        sbox u_sbox (
            .i_x (r_work[W-1-8*g -: 8]),
            .o_y (w_sub[SW-1-8*g -: 8])
        );
    end

    if (SBOXES == BYTES) begin : g_full
        assign w_rot = w_sub;
    end else begin : g_part
        assign w_rot = {r_work[W-SW-1:0], w_sub};
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    w_work_nxt  = data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_work_nxt = w_rot;
                w_cnt_nxt  = r_cnt + CW'(1);
                if (r_cnt == CW'(ROUNDS - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_work_nxt  = data_in;
                        w_cnt_nxt   = '0;
                        w_state_nxt = BUSY;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Partial results in BUSY are never exposed on data_out.
    assign data_out = (r_state == DONE) ? r_work : '0;

`ifdef GAMMA_ITER_BLKCNT_EN
    logic        w_out_fire;
    logic [31:0] r_blk_count;

    assign w_out_fire = (r_state == DONE) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_count <= '0;
        end else if (w_out_fire) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_gamma_iter.sv
// tb_gamma_iter: randomized self-checking bench for gamma_iter over 16/4, 16/1, 16/16 and 40/8 builds.
// Exercises blk_count as well when GAMMA_ITER_BLKCNT_EN is defined.
`timescale 1ns/1ps

module tb_gamma_iter;
    localparam logic [7:0] SBOX_REF [256] = '{
        8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79, 8'h3a, 8'hc9, 8'h91, 8'hfc, 8'h1e, 8'h47, 8'h54, 8'hbd,
        8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4, 8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2,
        8'h39, 8'hdf, 8'h29, 8'hda, 8'h2b, 8'ha8, 8'hcb, 8'h4c, 8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
        8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff, 8'h60, 8'h20, 8'h08, 8'h8b, 8'h5e, 8'hab, 8'h7f, 8'h78,
        8'h7c, 8'h2c, 8'h57, 8'hd2, 8'hdc, 8'h6d, 8'h7e, 8'h0d, 8'h53, 8'h94, 8'hc3, 8'h28, 8'h27, 8'h06, 8'h5f, 8'had,
        8'h67, 8'h5c, 8'h55, 8'h48, 8'h0e, 8'h52, 8'hea, 8'h42, 8'h5b, 8'h5d, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3c, 8'h4e,
        8'h38, 8'h8a, 8'h72, 8'h14, 8'he7, 8'hc6, 8'hde, 8'h50, 8'h8e, 8'h92, 8'hd1, 8'h77, 8'h93, 8'h45, 8'h9a, 8'hce,
        8'h2d, 8'h03, 8'h62, 8'hb6, 8'hb9, 8'hbf, 8'h96, 8'h6b, 8'h3f, 8'h07, 8'h12, 8'hae, 8'h40, 8'h34, 8'h46, 8'h3e,
        8'hdb, 8'hcf, 8'hec, 8'hcc, 8'hc1, 8'ha1, 8'hc0, 8'hd6, 8'h1d, 8'hf4, 8'h61, 8'h3b, 8'h10, 8'hd8, 8'h68, 8'ha0,
        8'hb1, 8'h0a, 8'h69, 8'h6c, 8'h49, 8'hfa, 8'h76, 8'hc4, 8'h9e, 8'h9b, 8'h6e, 8'h99, 8'hc2, 8'hb7, 8'h98, 8'hbc,
        8'h8f, 8'h85, 8'h1f, 8'hb4, 8'hf8, 8'h11, 8'h2e, 8'h00, 8'h25, 8'h1c, 8'h2a, 8'h3d, 8'h05, 8'h4f, 8'h7b, 8'hb2,
        8'h32, 8'h90, 8'haf, 8'h19, 8'ha3, 8'hf7, 8'h73, 8'h9d, 8'h15, 8'h74, 8'hee, 8'hca, 8'h9f, 8'h0f, 8'h1b, 8'h75,
        8'h86, 8'h84, 8'h9c, 8'h4a, 8'h97, 8'h1a, 8'h65, 8'hf6, 8'hed, 8'h09, 8'hbb, 8'h26, 8'h83, 8'heb, 8'h6f, 8'h81,
        8'h04, 8'h6a, 8'h43, 8'h01, 8'h17, 8'he1, 8'h87, 8'hf5, 8'h8d, 8'he3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
        8'hfe, 8'hd5, 8'h31, 8'hd9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hf2, 8'hf1, 8'h56, 8'hcd, 8'h82, 8'hc8, 8'hba, 8'hf0,
        8'hef, 8'he9, 8'he8, 8'hfd, 8'h89, 8'hd7, 8'hc7, 8'hb5, 8'ha4, 8'h2f, 8'h95, 8'h13, 8'h0b, 8'hf3, 8'he0, 8'h37
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   out_ready;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic [319:0] din;
    logic [127:0] dout0, dout1, dout2;
    logic [319:0] dout3;
`ifdef GAMMA_ITER_BLKCNT_EN
    logic [31:0]  bc0, bc1, bc2, bc3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gamma_iter #(.BYTES(16), .SBOXES(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .data_in(din[127:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(dout0)
`ifdef GAMMA_ITER_BLKCNT_EN
        , .blk_count(bc0)
`endif
    );

    gamma_iter #(.BYTES(16), .SBOXES(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .data_in(din[127:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(dout1)
`ifdef GAMMA_ITER_BLKCNT_EN
        , .blk_count(bc1)
`endif
    );

    gamma_iter #(.BYTES(16), .SBOXES(16)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .data_in(din[127:0]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .data_out(dout2)
`ifdef GAMMA_ITER_BLKCNT_EN
        , .blk_count(bc2)
`endif
    );

    gamma_iter #(.BYTES(40), .SBOXES(8)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .data_in(din),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .data_out(dout3)
`ifdef GAMMA_ITER_BLKCNT_EN
        , .blk_count(bc3)
`endif
    );

    function automatic int bytes_of(input int c);
        return (c == 3) ? 40 : 16;
    endfunction

    function automatic int latency_of(input int c);
        case (c)
            0:       return 16 / 4;
            1:       return 16 / 1;
            2:       return 16 / 16;
            default: return 40 / 8;
        endcase
    endfunction

    function automatic logic [319:0] get_dout(input int c);
        case (c)
            0:       return {192'd0, dout0};
            1:       return {192'd0, dout1};
            2:       return {192'd0, dout2};
            default: return dout3;
        endcase
    endfunction

    // Reference gamma: each byte replaced by its S-box image in place.
    function automatic logic [319:0] gamma_ref(input logic [319:0] x, input int nbytes);
        logic [319:0] y = '0;
        for (int i = 0; i < nbytes; i++) y[8*i +: 8] = SBOX_REF[x[8*i +: 8]];
        return y;
    endfunction

    function automatic logic [319:0] rand_state(input int nbytes);
        logic [319:0] v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic send(input int c, input logic [319:0] x);
        int n = 0;
        din = x;
        in_valid[c] = 1'b1;
        while (in_ready[c] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid[c] = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid; -1 on timeout.
    task automatic wait_valid(input int c, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (out_valid[c] !== 1'b1) begin
            if (in_ready[c] !== 1'b0) busy_ok = 1'b0;
            if (lat >= 200) begin
                lat = -1;
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic recv(input int c);
        out_ready[c] = 1'b1;
        @(posedge clk); #1;
        out_ready[c] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        din = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
        checks++;
        if (dout0 !== '0 || dout3 !== '0) begin errors++; $display("FAIL reset_data_out: got %h / %h expected 0", dout0, dout3); end
`ifdef GAMMA_ITER_BLKCNT_EN
        checks++;
        if ({bc0, bc1, bc2, bc3} !== '0) begin errors++; $display("FAIL reset_blk_count: got %h %h %h %h expected 0", bc0, bc1, bc2, bc3); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 4'b1111) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1111", in_ready); end
    endtask

    task automatic test_known_vectors();
        int lat;
        bit ok;
        logic [127:0] r;
        send(0, 320'd0);
        wait_valid(0, lat, ok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL zero_latency: got %0d expected 4", lat); end
        checks++;
        if (dout0 !== {16{8'ha7}}) begin errors++; $display("FAIL zero_data: got %h expected %h", dout0, {16{8'ha7}}); end
        recv(0);

        send(0, {192'd0, 128'h00010203040506070001020304050607});
        wait_valid(0, lat, ok);
        r = dout0;
        checks++;
        if (r !== 128'ha7d3e671d0ac4d79a7d3e671d0ac4d79) begin
            errors++; $display("FAIL vector_data: got %h expected a7d3e671d0ac4d79a7d3e671d0ac4d79", r);
        end
        recv(0);

        send(0, {192'd0, r});
        wait_valid(0, lat, ok);
        checks++;
        if (dout0 !== 128'h00010203040506070001020304050607) begin
            errors++; $display("FAIL involution: got %h expected 00010203040506070001020304050607", dout0);
        end
        recv(0);
    endtask

    task automatic test_sweep();
        int lat;
        bit ok;
        logic [319:0] x;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                x = rand_state(bytes_of(c));
                send(c, x);
                wait_valid(c, lat, ok);
                checks++;
                if (lat !== latency_of(c)) begin errors++; $display("FAIL sweep_latency cfg%0d: got %0d expected %0d", c, lat, latency_of(c)); end
                checks++;
                if (!ok) begin errors++; $display("FAIL sweep_busy_ready cfg%0d: got in_ready high expected low", c); end
                checks++;
                if (get_dout(c) !== gamma_ref(x, bytes_of(c))) begin
                    errors++; $display("FAIL sweep_data cfg%0d: got %h expected %h", c, get_dout(c), gamma_ref(x, bytes_of(c)));
                end
                recv(c);
                checks++;
                if (out_valid[c] !== 1'b0) begin errors++; $display("FAIL sweep_release cfg%0d: got out_valid 1 expected 0", c); end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        logic [319:0] x, z, exp_x;
        x = rand_state(16);
        exp_x = gamma_ref(x, 16);
        send(0, x);
        wait_valid(0, lat, ok);
        din = rand_state(16);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || {192'd0, dout0} !== exp_x || in_ready[0] !== 1'b0) begin
                errors++; $display("FAIL hold cycle%0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                                   i, out_valid[0], in_ready[0], dout0, exp_x[127:0]);
            end
            @(posedge clk); #1;
        end
        z = rand_state(16);
        din = z;
        out_ready[0] = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready[0]); end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        wait_valid(0, lat, ok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL overlap_latency: got %0d expected 4", lat); end
        checks++;
        if ({192'd0, dout0} !== gamma_ref(z, 16)) begin errors++; $display("FAIL overlap_data: got %h expected %h", dout0, gamma_ref(z, 16)); end
        recv(0);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        logic [319:0] blk [4];
        for (int i = 0; i < 4; i++) blk[i] = rand_state(16);
        out_ready[0] = 1'b1;
        send(0, blk[0]);
        in_valid[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) din = blk[i];
            else in_valid[0] = 1'b0;
            wait_valid(0, lat, ok);
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL b2b_latency blk%0d: got %0d expected 4", i - 1, lat); end
            checks++;
            if ({192'd0, dout0} !== gamma_ref(blk[i-1], 16)) begin
                errors++; $display("FAIL b2b_data blk%0d: got %h expected %h", i - 1, dout0, gamma_ref(blk[i-1], 16));
            end
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        bit ok;
        logic [319:0] x;
        send(0, rand_state(16));
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || dout0 !== '0 || in_ready[0] !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got valid=%b ready=%b data=%h expected 0 0 0", out_valid[0], in_ready[0], dout0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid[0] !== 1'b0 || dout0 !== '0) begin
                errors++; $display("FAIL after_reset cycle%0d: got valid=%b data=%h expected 0 0", i, out_valid[0], dout0);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL after_reset_ready: got %b expected 1", in_ready[0]); end
        x = rand_state(16);
        send(0, x);
        wait_valid(0, lat, ok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL after_reset_latency: got %0d expected 4", lat); end
        checks++;
        if ({192'd0, dout0} !== gamma_ref(x, 16)) begin errors++; $display("FAIL after_reset_data: got %h expected %h", dout0, gamma_ref(x, 16)); end
        recv(0);
    endtask

`ifdef GAMMA_ITER_BLKCNT_EN
    task automatic test_blkcnt();
        int lat;
        bit ok;
        rst = 1'b1;
        #1;
        checks++;
        if (bc0 !== 32'd0) begin errors++; $display("FAIL blkcnt_in_reset: got %0d expected 0", bc0); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, rand_state(16));
            wait_valid(0, lat, ok);
            recv(0);
        end
        checks++;
        if (bc0 !== 32'd3) begin errors++; $display("FAIL blkcnt: got %0d expected 3", bc0); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_vectors();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef GAMMA_ITER_BLKCNT_EN
        test_blkcnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gamma_iter.md
Name: gamma_iter

Overview:
- Sequential, parametrised successor to the combinational gamma layer.
- Applies the Anubis involutive S-box to every byte of a BYTES-wide state, SBOXES bytes per clock, behind valid/ready handshakes.
- Serves both the 128-bit cipher datapath (BYTES=16) and the key schedule (BYTES=4N, N=4..10), with area/latency traded via SBOXES.
- Instantiates the existing 8-bit combinational sbox module SBOXES times.

Parameters:
- BYTES, 16: state width in bytes; data width is 8*BYTES.
- SBOXES, 4: S-box instances used per cycle; must divide BYTES, else an elaboration error is raised.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept data_in this cycle.
- data_in  input  8*BYTES  state; byte 0 = data_in[8*BYTES-1:8*BYTES-8].
- out_valid  output  1  data_out holds a complete result.
- out_ready  input  1  consumer accepts data_out.
- data_out  output  8*BYTES  substituted state, same byte order as data_in.

Behaviour:
- Reset values (async, immediate):
  - state = IDLE; work register, round counter and data_out = 0.
  - out_valid = 0; in_ready = 0 while rst is high, then 1 from the first cycle after release.
- Derived constants:
  - ROUNDS = BYTES/SBOXES.
  - Counter width = clog2(ROUNDS+1).
- FSM, IDLE -> BUSY -> DONE:
  - IDLE: in_ready = 1. On in_valid && in_ready, load data_in into the work register, clear the counter and go to BUSY.
  - BUSY: in_ready = 0. Each cycle, replace the top SBOXES bytes with sbox(byte), rotate the register left by 8*SBOXES and increment the counter. When counter == ROUNDS-1, go to DONE; the work register then holds every byte substituted, in original order.
  - DONE: out_valid = 1 and data_out = work register, stable until the output handshake.
    - On out_valid && out_ready, go to IDLE, or to BUSY if a new input is accepted in the same cycle.
    - in_ready = out_ready in DONE, so back-to-back blocks need no bubble.
- Latency:
  - Accept at edge k gives out_valid high after edge k+ROUNDS.
  - Throughput is one block per ROUNDS cycles when out_ready is held high.
- SBOXES == BYTES: single BUSY cycle, latency 1.
- in_valid while in BUSY, or while in DONE with out_ready = 0: ignored, no state change. The producer must hold data_in.
- out_ready without out_valid: no effect.
- out_ready held low in DONE: data_out and out_valid hold indefinitely.
- rst asserted mid-BUSY or in DONE: the block is discarded and the FSM returns to IDLE with reset values. No partial result is ever presented.
- data_in is sampled only on the accepting edge; later changes to it have no effect.

Optional Feature:
- Macro: GAMMA_ITER_BLKCNT_EN.
- When defined, add output blk_count [31:0]:
  - Reset to 0.
  - Increments by 1 on each output handshake (out_valid && out_ready).
  - Wraps from 0xFFFFFFFF to 0.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Defaults (16/4), data_in = 0 with out_ready = 1 -> data_out = a7a7a7a7a7a7a7a7a7a7a7a7a7a7a7a7, out_valid 4 cycles after accept.
- data_in = 00010203040506070001020304050607 -> data_out = a7d3e671d0ac4d79a7d3e671d0ac4d79. Feeding that result back returns the original input (involution check).
- Sweep BYTES/SBOXES over 16/1, 16/16 and 40/8 with random inputs, compared against a per-byte S-box reference:
  - latencies are 16, 1 and 5 cycles respectively;
  - in_ready stays low while BUSY.
- Backpressure:
  - out_ready low for 10 cycles -> data_out and out_valid stable, and a new in_valid is not accepted.
  - Raising out_ready together with in_valid -> both handshakes complete on the same edge and the next result arrives 4 cycles later.
- Assert rst for 1 cycle mid-BUSY (counter = 2):
  - out_valid stays 0 and data_out = 0;
  - the next accepted block completes correctly with full latency.
- With GAMMA_ITER_BLKCNT_EN defined, run 3 blocks -> blk_count = 3, with blk_count held at 0 during reset.
